// File: rtl/fft8_bfly_stage_if.sv
// fft8_bfly_stage_if: stream interface of one radix-2 DIT butterfly stage.
//   in_valid/in_ready/in_sof/in_x0/in_x1    : input pair stream (packed complex Q4.12)
//   out_valid/out_ready/out_sof/out_y0/out_y1 : output pair stream (packed complex Q4.12)
//   master : the side feeding pairs in and consuming results (producer/consumer)
//   slave  : the butterfly stage itself
interface fft8_bfly_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic [31:0] in_x0;
  logic [31:0] in_x1;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic [31:0] out_y0;
  logic [31:0] out_y1;

  modport master (
    output in_valid, in_sof, in_x0, in_x1, out_ready,
    input  in_ready, out_valid, out_sof, out_y0, out_y1
  );

  modport slave (
    input  in_valid, in_sof, in_x0, in_x1, out_ready,
    output in_ready, out_valid, out_sof, out_y0, out_y1
  );
endinterface

// File: rtl/fft8_bfly_stage.sv
// fft8_bfly_stage: three-register pipelined radix-2 DIT butterfly for one
// stage of an 8-point FFT. y0 = x0 + x1*W, y1 = x0 - x1*W, with W = W8^k taken
// from a 4-entry Q4.12 ROM. Packed complex: [31:16] real, [15:0] imag.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of fft8_bfly_stage_if (input pair stream, output pair stream)
// Parameters: STAGE (0..2) selects the twiddle sequence, SCALE (0/1) is the
// output arithmetic right shift, SAT selects saturation (1) or wrap (0).
module fft8_bfly_stage #(
  parameter int STAGE = 0,
  parameter int SCALE = 1,
  parameter int SAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  fft8_bfly_stage_if.slave  bus
);

  // Complex Q4.12 product; each component keeps bits [27:12] of the exact sum
  // (floor of the >>12, wrapped to 16 bits).
  function automatic logic [31:0] cmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [15:0] ar, ai, br, bi;
    logic signed [31:0] rr, ii, ri, ir;
    logic signed [32:0] re, im;
    ar = a[31:16];
    ai = a[15:0];
    br = b[31:16];
    bi = b[15:0];
    rr = ar * br;
    ii = ai * bi;
    ri = ar * bi;
    ir = ai * br;
    re = {rr[31], rr} - {ii[31], ii};
    im = {ri[31], ri} + {ir[31], ir};
    return {16'(re >>> 12), 16'(im >>> 12)};
  endfunction

  // One output component: 17-bit sum/difference, scale, then clamp or wrap.
  function automatic logic [15:0] bf_comp(input logic [15:0] x, input logic [15:0] p,
                                          input logic sub);
    logic signed [16:0] s, r;
    logic [15:0]        res;
    if (sub) begin
      s = {x[15], x} - {p[15], p};
    end else begin
      s = {x[15], x} + {p[15], p};
    end
    r = s >>> SCALE;
    if ((SAT != 0) && (r[16] != r[15])) begin
      res = r[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      res = r[15:0];
    end
    return res;
  endfunction

  // Twiddle ROM W8^k in Q4.12.
  function automatic logic [31:0] twiddle(input logic [1:0] k);
    logic [31:0] w;
    case (k)
      2'd0:    w = 32'h1000_0000;
      2'd1:    w = 32'h0B50_F4B0;
      2'd2:    w = 32'h0000_F000;
      2'd3:    w = 32'hF4B0_F4B0;
      default: w = 32'h1000_0000;
    endcase
    return w;
  endfunction

  logic        adv_s;
  logic        acc_s;
  logic [1:0]  j_use_s;
  logic [1:0]  k_s;
  logic [1:0]  j_r;

  logic        v1_r, sof1_r;
  logic [31:0] x0_1_r, x1_1_r, w1_r;
  logic        v2_r, sof2_r;
  logic [31:0] x0_2_r, p2_r;
  logic        out_valid_r, out_sof_r;
  logic [31:0] out_y0_r, out_y1_r;

  // Whole pipeline advances together unless a held output is being stalled.
  assign adv_s        = !out_valid_r || bus.out_ready;
  assign acc_s        = bus.in_valid && adv_s;
  assign bus.in_ready = adv_s;

  assign bus.out_valid = out_valid_r;
  assign bus.out_sof   = out_sof_r;
  assign bus.out_y0    = out_y0_r;
  assign bus.out_y1    = out_y1_r;

  // Pair index of the current beat (sof restarts the frame) and twiddle exponent.
  always_comb begin
    j_use_s = bus.in_sof ? 2'd0 : j_r;
    case (STAGE)
      1:       k_s = {j_use_s[0], 1'b0};
      2:       k_s = j_use_s;
      default: k_s = 2'd0;
    endcase
  end

  // Pair counter: moves only on accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j_r <= 2'd0;
    end else if (acc_s) begin
      j_r <= j_use_s + 2'd1;
    end else begin
      j_r <= j_r;
    end
  end

  // Three pipeline stages: operand/twiddle capture, multiply, butterfly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r        <= 1'b0;
      sof1_r      <= 1'b0;
      x0_1_r      <= 32'h0;
      x1_1_r      <= 32'h0;
      w1_r        <= 32'h0;
      v2_r        <= 1'b0;
      sof2_r      <= 1'b0;
      x0_2_r      <= 32'h0;
      p2_r        <= 32'h0;
      out_valid_r <= 1'b0;
      out_sof_r   <= 1'b0;
      out_y0_r    <= 32'h0;
      out_y1_r    <= 32'h0;
    end else if (adv_s) begin
      v1_r        <= bus.in_valid;
      sof1_r      <= bus.in_sof && bus.in_valid;
      x0_1_r      <= bus.in_x0;
      x1_1_r      <= bus.in_x1;
      w1_r        <= twiddle(k_s);
      v2_r        <= v1_r;
      sof2_r      <= sof1_r;
      x0_2_r      <= x0_1_r;
      p2_r        <= cmul(x1_1_r, w1_r);
      out_valid_r <= v2_r;
      out_sof_r   <= sof2_r;
      out_y0_r    <= {bf_comp(x0_2_r[31:16], p2_r[31:16], 1'b0),
                      bf_comp(x0_2_r[15:0],  p2_r[15:0],  1'b0)};
      out_y1_r    <= {bf_comp(x0_2_r[31:16], p2_r[31:16], 1'b1),
                      bf_comp(x0_2_r[15:0],  p2_r[15:0],  1'b1)};
    end else begin
      v1_r        <= v1_r;
      sof1_r      <= sof1_r;
      x0_1_r      <= x0_1_r;
      x1_1_r      <= x1_1_r;
      w1_r        <= w1_r;
      v2_r        <= v2_r;
      sof2_r      <= sof2_r;
      x0_2_r      <= x0_2_r;
      p2_r        <= p2_r;
      out_valid_r <= out_valid_r;
      out_sof_r   <= out_sof_r;
      out_y0_r    <= out_y0_r;
      out_y1_r    <= out_y1_r;
    end
  end

endmodule

// File: tb/tb_fft8_bfly_stage.sv
// tb_fft8_bfly_stage: directed self-checking bench. Five stage configurations
// share one stimulus stream; each test checks the instances it is aimed at.
//   ifa: STAGE0 SCALE1 SAT1   ifb: STAGE2 SCALE0 SAT1   ifc: STAGE0 SCALE0 SAT1
//   ifd: STAGE0 SCALE0 SAT0   ife: STAGE1 SCALE0 SAT1
module tb_fft8_bfly_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sof, out_ready;
  logic [31:0] in_x0, in_x1;

  always #5 clk = ~clk;

  fft8_bfly_stage_if ifa ();
  fft8_bfly_stage_if ifb ();
  fft8_bfly_stage_if ifc ();
  fft8_bfly_stage_if ifd ();
  fft8_bfly_stage_if ife ();

  assign ifa.in_valid = in_valid;  assign ifa.in_sof = in_sof;  assign ifa.in_x0 = in_x0;
  assign ifa.in_x1 = in_x1;        assign ifa.out_ready = out_ready;
  assign ifb.in_valid = in_valid;  assign ifb.in_sof = in_sof;  assign ifb.in_x0 = in_x0;
  assign ifb.in_x1 = in_x1;        assign ifb.out_ready = out_ready;
  assign ifc.in_valid = in_valid;  assign ifc.in_sof = in_sof;  assign ifc.in_x0 = in_x0;
  assign ifc.in_x1 = in_x1;        assign ifc.out_ready = out_ready;
  assign ifd.in_valid = in_valid;  assign ifd.in_sof = in_sof;  assign ifd.in_x0 = in_x0;
  assign ifd.in_x1 = in_x1;        assign ifd.out_ready = out_ready;
  assign ife.in_valid = in_valid;  assign ife.in_sof = in_sof;  assign ife.in_x0 = in_x0;
  assign ife.in_x1 = in_x1;        assign ife.out_ready = out_ready;

  fft8_bfly_stage #(.STAGE(0), .SCALE(1), .SAT(1)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  fft8_bfly_stage #(.STAGE(2), .SCALE(0), .SAT(1)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  fft8_bfly_stage #(.STAGE(0), .SCALE(0), .SAT(1)) u_c (.clk(clk), .rst(rst), .bus(ifc.slave));
  fft8_bfly_stage #(.STAGE(0), .SCALE(0), .SAT(0)) u_d (.clk(clk), .rst(rst), .bus(ifd.slave));
  fft8_bfly_stage #(.STAGE(1), .SCALE(0), .SAT(1)) u_e (.clk(clk), .rst(rst), .bus(ife.slave));

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] w_tab  [4] = '{32'h1000_0000, 32'h0B50_F4B0, 32'h0000_F000, 32'hF4B0_F4B0};
  logic [31:0] wn_tab [4] = '{32'hF000_0000, 32'hF4B0_0B50, 32'h0000_1000, 32'h0B50_0B50};

  // sof on the 3rd and 6th beats; expected twiddle index for STAGE2 / STAGE1.
  logic t5_sof [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  int   t5_kb  [7] = '{0, 1, 0, 1, 2, 0, 1};
  int   t5_ke  [7] = '{0, 2, 0, 2, 0, 0, 2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_sof   = s;
    in_x0    = a;
    in_x1    = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, got, cyc, m;
    logic acc, stalled_prev;
    logic [31:0] hold_y0, hold_y1, exp_y;

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_x0 = 32'h0; in_x1 = 32'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ifa.out_valid, 32'd0);
    chk("rst_sof",   ifa.out_sof,   32'd0);
    chk("rst_y0",    ifa.out_y0,    32'h0);
    chk("rst_y1",    ifa.out_y1,    32'h0);
    chk("rst_ready", ifa.in_ready,  32'd1);
    rst = 1'b0;

    // T1: single beat, latency 3
    step(1'b1, 1'b1, 32'h1000_0000, 32'h1000_1000);
    chk("t1_lat1", ifa.out_valid, 32'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_lat2", ifa.out_valid, 32'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_valid", ifa.out_valid, 32'd1);
    chk("t1_y0",    ifa.out_y0,    32'h1000_0800);
    chk("t1_y1",    ifa.out_y1,    32'h0000_F800);
    chk("t1_sof",   ifa.out_sof,   32'd1);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_bubble", ifa.out_valid, 32'd0);

    // T2: STAGE2 twiddle sweep, x1 = 1.0
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(1'b1, (i == 0), 32'h0, 32'h1000_0000);
      else       step(1'b0, 1'b0, 32'h0, 32'h0);
      if (i >= 2) begin
        m = i - 2;
        chk($sformatf("t2_valid_%0d", m), ifb.out_valid, 32'd1);
        chk($sformatf("t2_y0_%0d", m),    ifb.out_y0,    w_tab[m]);
        chk($sformatf("t2_y1_%0d", m),    ifb.out_y1,    wn_tab[m]);
        chk($sformatf("t2_sof_%0d", m),   ifb.out_sof,   (m == 0) ? 32'd1 : 32'd0);
      end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t2_drain", ifb.out_valid, 32'd0);

    // T4: saturation vs wrap, and scaling preventing growth
    step(1'b1, 1'b1, 32'h7FFF_0000, 32'h7FFF_0000);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t4_sat_y0",   ifc.out_y0, 32'h7FFF_0000);
    chk("t4_sat_y1",   ifc.out_y1, 32'h0000_0000);
    chk("t4_wrap_y0",  ifd.out_y0, 32'hFFFE_0000);
    chk("t4_wrap_y1",  ifd.out_y1, 32'h0000_0000);
    chk("t4_scale_y0", ifa.out_y0, 32'h7FFF_0000);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // T5: sof mid-frame restarts the pair counter
    for (int i = 0; i < 9; i++) begin
      if (i < 7) step(1'b1, t5_sof[i], 32'h0, 32'h1000_0000);
      else       step(1'b0, 1'b0, 32'h0, 32'h0);
      if (i >= 2) begin
        m = i - 2;
        chk($sformatf("t5_valid_%0d", m), ife.out_valid, 32'd1);
        chk($sformatf("t5_s1_y0_%0d", m), ife.out_y0,    w_tab[t5_ke[m]]);
        chk($sformatf("t5_sof_%0d", m),   ife.out_sof,   {31'd0, t5_sof[m]});
        chk($sformatf("t5_s2_y0_%0d", m), ifb.out_y0,    w_tab[t5_kb[m]]);
      end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // T3: 8-beat stream with a 5-cycle output stall
    sent = 0; got = 0; cyc = 0; stalled_prev = 1'b0; hold_y0 = 32'h0; hold_y1 = 32'h0;
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc < 10);
      in_valid  = (sent < 8);
      in_sof    = (sent == 0);
      in_x0     = {16'(sent * 32'h200), 16'h0};
      in_x1     = 32'h0;
      #1;
      if (ifa.out_valid) begin
        if (stalled_prev) begin
          chk("t3_hold_y0", ifa.out_y0, hold_y0);
          chk("t3_hold_y1", ifa.out_y1, hold_y1);
        end
        if (out_ready) begin
          exp_y = {16'(got * 32'h100), 16'h0};
          chk($sformatf("t3_y0_%0d", got), ifa.out_y0, exp_y);
          chk($sformatf("t3_y1_%0d", got), ifa.out_y1, exp_y);
          chk($sformatf("t3_sof_%0d", got), ifa.out_sof, (got == 0) ? 32'd1 : 32'd0);
          got++;
          stalled_prev = 1'b0;
        end else begin
          chk("t3_stall_ready", ifa.in_ready, 32'd0);
          hold_y0 = ifa.out_y0;
          hold_y1 = ifa.out_y1;
          stalled_prev = 1'b1;
        end
      end else begin
        stalled_prev = 1'b0;
      end
      acc = in_valid && ifa.in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    chk("t3_count", got, 32'd8);
    chk("t3_sent",  sent, 32'd8);
    out_ready = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t3_drain", ifa.out_valid, 32'd0);

    // T6: reset with pairs in flight
    step(1'b1, 1'b1, 32'h1000_0000, 32'h1000_0000);
    step(1'b1, 1'b0, 32'h1000_0000, 32'h1000_0000);
    step(1'b1, 1'b0, 32'h1000_0000, 32'h1000_0000);
    chk("t6_pre_valid", ifa.out_valid, 32'd1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst      = 1'b1;
    #1;
    chk("t6_rst_valid", ifa.out_valid, 32'd0);
    chk("t6_rst_y0",    ifa.out_y0,    32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("t6_stale_%0d", i), ifa.out_valid, 32'd0);
    end
    step(1'b1, 1'b0, 32'h0, 32'h1000_0000);
    step(1'b1, 1'b0, 32'h0, 32'h1000_0000);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t6_post_valid", ifb.out_valid, 32'd1);
    chk("t6_post_w0",    ifb.out_y0,    w_tab[0]);
    chk("t6_post_sof",   ifb.out_sof,   32'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t6_post_w1",    ifb.out_y0,    w_tab[1]);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
